// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Optional ALU_ARB_DIVZ_EN: short-circuit divide-by-zero with a marked response.
module alu_arbiter #(
  parameter int N             = 20,
  parameter int MULDIV_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [2:0]   req0_op,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [2:0]   req1_op,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [2:0]   alu_op,
  input  logic [N-1:0] alu_result,
  input  logic         alu_z,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_result,
  output logic         rsp_z,
  output logic         rsp_id,
  output logic         rsp_divz
);

  localparam int CW = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rr_q, rr_d;
  logic [N-1:0]  alu_a_q, alu_a_d;
  logic [N-1:0]  alu_b_q, alu_b_d;
  logic [2:0]    alu_op_q, alu_op_d;
  logic          id_q, id_d;
  logic          dz_q, dz_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [N-1:0]  rsp_result_q, rsp_result_d;
  logic          rsp_z_q, rsp_z_d;
  logic          rsp_divz_q, rsp_divz_d;

  logic          gnt0, gnt1, hs;
  logic [N-1:0]  sel_a, sel_b;
  logic [2:0]    sel_op;
  logic          sel_md, divz_hit;

  // Pick a requester: rr_q=1 favours req1 when both are valid
  always_comb begin
    gnt1   = req1_valid && (!req0_valid || rr_q);
    gnt0   = req0_valid && !gnt1;
    sel_a  = gnt1 ? req1_a : req0_a;
    sel_b  = gnt1 ? req1_b : req0_b;
    sel_op = gnt1 ? req1_op : req0_op;
    sel_md = (sel_op == 3'b010) || (sel_op == 3'b011);
  end

`ifdef ALU_ARB_DIVZ_EN
  assign divz_hit = (sel_op == 3'b011) && (sel_b == '0);
`else
  assign divz_hit = 1'b0;
`endif

  assign req0_ready = (state_q == IDLE) && gnt0;
  assign req1_ready = (state_q == IDLE) && gnt1;
  assign hs         = req0_ready || req1_ready;

  // Next-state and datapath update for grant, wait and response
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rr_d         = rr_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    id_d         = id_q;
    dz_d         = dz_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_z_d      = rsp_z_q;
    rsp_divz_d   = rsp_divz_q;
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          alu_a_d  = sel_a;
          alu_b_d  = sel_b;
          alu_op_d = sel_op;
          id_d     = gnt1;
          rr_d     = !gnt1;
          dz_d     = divz_hit;
          if (sel_md && !divz_hit)
            cnt_d = CW'(MULDIV_CYCLES - 1);
          else
            cnt_d = '0;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          rsp_result_d = dz_q ? '1 : alu_result;
          rsp_z_d      = alu_z && !dz_q;
          rsp_divz_d   = dz_q;
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops any op in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rr_q         <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      id_q         <= 1'b0;
      dz_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_z_q      <= 1'b0;
      rsp_divz_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rr_q         <= rr_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      id_q         <= id_d;
      dz_q         <= dz_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_z_q      <= rsp_z_d;
      rsp_divz_q   <= rsp_divz_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_z      = rsp_z_q;
  assign rsp_id     = id_q;
  assign rsp_divz   = rsp_divz_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: models the shared ALU, scoreboards responses.
// Honours ALU_ARB_DIVZ_EN for divide-by-zero expectations.
module tb_alu_arbiter;

  localparam int N  = 20;
  localparam int MD = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready;
  logic [N-1:0] req0_a, req0_b;
  logic [2:0]   req0_op;
  logic         req1_valid, req1_ready;
  logic [N-1:0] req1_a, req1_b;
  logic [2:0]   req1_op;
  logic [N-1:0] alu_a, alu_b, alu_result;
  logic [2:0]   alu_op;
  logic         alu_z;
  logic         rsp_valid, rsp_ready;
  logic [N-1:0] rsp_result;
  logic         rsp_z, rsp_id, rsp_divz;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   op;
    logic         id;
    logic [N-1:0] res;
    logic         z;
    logic         dz;
    int           due;
  } exp_t;

  exp_t         sb[$];
  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;
  int           npush = 0;
  bit           mrr;
  bit           hs_seen;
  bit           pend_prev;
  logic [N+2:0] held;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [N-1:0] alu_f(logic [N-1:0] a, logic [N-1:0] b,
                                         logic [2:0] op);
    logic [N-1:0] r;
    case (op)
      3'b000: r = a + b;
      3'b001: r = a - b;
      3'b010: r = a * b;
      3'b011: r = (b == '0) ? '0 : a / b;
      3'b100: r = a & b;
      3'b101: r = a | b;
      3'b110: r = a << b;
      default: r = a >> b;
    endcase
    return r;
  endfunction

  assign alu_result = alu_f(alu_a, alu_b, alu_op);
  assign alu_z      = (alu_result == '0);

  alu_arbiter #(.N(N), .MULDIV_CYCLES(MD)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_z(alu_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_z(rsp_z),
    .rsp_id(rsp_id), .rsp_divz(rsp_divz)
  );

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(bit id, logic [N-1:0] a, logic [N-1:0] b,
                      logic [2:0] op);
    exp_t e;
    bit   md;
    if (req0_valid && req1_valid) chk("rr_grant", id, mrr);
    mrr   = !id;
    md    = (op == 3'b010) || (op == 3'b011);
    e.a   = a;
    e.b   = b;
    e.op  = op;
    e.id  = id;
    e.res = alu_f(a, b, op);
    e.z   = (e.res == '0);
    e.dz  = 1'b0;
    e.due = cyc + (md ? 1 + MD : 2);
`ifdef ALU_ARB_DIVZ_EN
    if (op == 3'b011 && b == '0) begin
      e.res = '1;
      e.z   = 1'b0;
      e.dz  = 1'b1;
      e.due = cyc + 2;
    end
`endif
    sb.push_back(e);
    npush++;
    hs_seen = 1'b1;
  endtask

  // One cycle: sample just after the falling edge, then wait for the next one
  task automatic step();
    exp_t e;
    bit   pushed;
    pushed = 1'b0;
    #1;
    if (req0_ready && req1_ready) chk("one_ready", req1_ready, 1'b0);
    if (req0_valid && req0_ready) begin
      push(1'b0, req0_a, req0_b, req0_op);
      pushed = 1'b1;
    end
    if (req1_valid && req1_ready) begin
      push(1'b1, req1_a, req1_b, req1_op);
      pushed = 1'b1;
    end
    if (sb.size() != 0 && !pushed && !rsp_valid)
      chk("alu_hold", {alu_a, alu_b, alu_op},
          {sb[0].a, sb[0].b, sb[0].op});
    if (rsp_valid && !pend_prev) begin
      if (sb.size() == 0) chk("spurious_rsp", rsp_valid, 1'b0);
      else chk("latency", cyc, sb[0].due);
    end
    if (rsp_valid)
      chk("no_grant_in_resp", {req0_ready, req1_ready}, 2'b00);
    if (rsp_valid && pend_prev)
      chk("rsp_hold", {rsp_result, rsp_z, rsp_id, rsp_divz}, held);
    if (rsp_valid && rsp_ready && sb.size() != 0) begin
      e = sb.pop_front();
      chk("rsp_result", rsp_result, e.res);
      chk("rsp_z", rsp_z, e.z);
      chk("rsp_id", rsp_id, e.id);
      chk("rsp_divz", rsp_divz, e.dz);
    end
    pend_prev = rsp_valid && !rsp_ready;
    held      = {rsp_result, rsp_z, rsp_id, rsp_divz};
    @(negedge clk);
  endtask

  task automatic issue(bit id, logic [N-1:0] a, logic [N-1:0] b,
                       logic [2:0] op);
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end
    hs_seen = 1'b0;
    for (int i = 0; i < 40 && !hs_seen; i++) step();
    chk("grant_timeout", hs_seen, 1'b1);
    if (id) req1_valid = 1'b0;
    else req0_valid = 1'b0;
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    for (int i = 0; i < 40 && sb.size() != 0; i++) step();
    chk("drain_timeout", sb.size(), 0);
  endtask

  task automatic chk_reset_vals(string tag);
    chk(tag, {alu_a, alu_b, alu_op, rsp_valid, rsp_result,
              rsp_z, rsp_id, rsp_divz}, '0);
  endtask

  initial begin
    int n0;
    rst_n = 1'b0;
    {req0_valid, req0_a, req0_b, req0_op} = '0;
    {req1_valid, req1_a, req1_b, req1_op} = '0;
    rsp_ready = 1'b0;
    mrr = 1'b0;
    pend_prev = 1'b0;
    held = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk_reset_vals("reset_outs");
    chk("reset_ready", {req0_ready, req1_ready}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Both requesters valid every cycle: grants must alternate from req0
    rsp_ready = 1'b1;
    n0 = npush;
    {req0_valid, req0_a, req0_b, req0_op} = {1'b1, 20'd7, 20'd7, 3'b001};
    {req1_valid, req1_a, req1_b, req1_op} = {1'b1, 20'd7, 20'd7, 3'b001};
    for (int i = 0; i < 14; i++) step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("alt_grants", npush - n0 >= 4, 1'b1);
    drain();

    // Simple add, then a multi-cycle mul from req1
    issue(1'b0, 20'd5, 20'd3, 3'b000);
    drain();
    issue(1'b1, 20'd6, 20'd7, 3'b010);
    drain();

    // Back-pressure: response held while rsp_ready is low
    rsp_ready = 1'b0;
    issue(1'b0, 20'h12345, 20'h00F0F, 3'b100);
    {req1_valid, req1_a, req1_b, req1_op} = {1'b1, 20'd1, 20'd1, 3'b001};
    for (int i = 0; i < 20 && !rsp_valid; i++) step();
    chk("bp_rsp_seen", rsp_valid, 1'b1);
    for (int i = 0; i < 5; i++) step();
    chk("no_early_grant", sb.size(), 1);
    rsp_ready = 1'b1;
    hs_seen = 1'b0;
    for (int i = 0; i < 20 && !hs_seen; i++) step();
    chk("bp_next_grant", hs_seen, 1'b1);
    req1_valid = 1'b0;
    drain();

    // Divide by zero, normal divide, and assorted ops
    issue(1'b0, 20'd9, 20'd0, 3'b011);
    drain();
    issue(1'b1, 20'd100, 20'd7, 3'b011);
    drain();
    issue(1'b0, 20'hF0F00, 20'h0F0F0, 3'b101);
    drain();
    issue(1'b1, 20'h00013, 20'd3, 3'b110);
    drain();
    issue(1'b0, 20'hABCDE, 20'd2, 3'b111);
    drain();
    issue(1'b1, 20'h00001, 20'd25, 3'b110);
    drain();
    issue(1'b0, 20'hFFFFF, 20'd3, 3'b010);
    drain();
    issue(1'b1, 20'd3, 20'd5, 3'b001);
    drain();

    // Reset in the middle of a req0 mul
    issue(1'b0, 20'd1234, 20'd5, 3'b010);
    step();
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midreset_outs");
    sb.delete();
    pend_prev = 1'b0;
    mrr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step();
    {req0_valid, req0_a, req0_b, req0_op} = {1'b1, 20'd1, 20'd2, 3'b000};
    {req1_valid, req1_a, req1_b, req1_op} = {1'b1, 20'd3, 20'd4, 3'b000};
    #1;
    chk("post_reset_grant", {req0_ready, req1_ready}, 2'b10);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
